// File: rtl/demux_pkg.sv
// demux_pkg: shared definitions for the N-way registered demultiplexer.
//   sel_w_f      - selector width for a given channel count (clog2, minimum 1)
//   slot_state_t - per-channel slot state (EMPTY / FULL)
//   CNT_W        - width of the optional per-channel handshake counters
package demux_pkg;

   localparam int CNT_W = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   function automatic int sel_w_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   wr_en      - load wr_data this cycle (caller guarantees writable)
//   wr_data    - word to load
//   rd_ready   - consumer accepts the held word this cycle
//   valid      - a word is held
//   data       - held word (stable while valid & !rd_ready)
//   writable   - slot can take a write this cycle (empty, or draining now)
//   cnt        - completed output handshakes, wraps (only with DEMUX_COUNT_EN)
// Optional feature macro: DEMUX_COUNT_EN.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             writable
`ifdef DEMUX_COUNT_EN
   ,
   output logic [CNT_W-1:0] cnt
`endif
);

   slot_state_t state;

   // A write wins over a drain: a simultaneous drain+write leaves the slot
   // FULL with the new word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         data  <= '0;
      end else if (wr_en) begin
         state <= FULL;
         data  <= wr_data;
      end else if (state == FULL && rd_ready) begin
         state <= EMPTY;
      end
   end

   assign valid    = (state == FULL);
   // Pass-through refill: a draining slot accepts a new word the same cycle.
   assign writable = (state == EMPTY) || rd_ready;

`ifdef DEMUX_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (valid && rd_ready)
         cnt <= cnt + 1'b1;
   end
`endif

endmodule

// File: rtl/demux_router_n.sv
// demux_router_n: registered N-way demultiplexer with valid/ready handshaking.
// Routes one word per cycle to channel in_sel, or to every channel when
// in_bcast is set; each channel holds its word until its consumer accepts it.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake
//   in_data, in_sel      - input word and destination channel
//   in_bcast             - deliver to all channels (all-or-nothing)
//   out_valid/out_ready  - per-channel output handshake
//   out_data             - channel k at [k*WIDTH +: WIDTH]
//   sel_err              - sticky: unicast word seen with in_sel >= N_OUT
//   cnt_out              - per-channel 16-bit drain counters (DEMUX_COUNT_EN)
// Optional feature macro: DEMUX_COUNT_EN.
module demux_router_n
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_OUT = 4,
   parameter int SEL_W = sel_w_f(N_OUT)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_bcast,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic                   sel_err
`ifdef DEMUX_COUNT_EN
   ,
   output logic [N_OUT*CNT_W-1:0] cnt_out
`endif
);

   logic [N_OUT-1:0] writable;
   logic [N_OUT-1:0] sel_hit;
   logic [N_OUT-1:0] wr_en;
   logic             sel_oor;

   // Out-of-range selectors only exist when N_OUT is not a power of two.
   assign sel_oor = ({1'b0, in_sel} >= (SEL_W+1)'(N_OUT));

   // in_ready never depends on in_valid.
   always_comb begin
      in_ready = 1'b0;
      if (in_bcast)
         in_ready = &writable;
      else if (sel_oor)
         in_ready = 1'b1;                 // dropped word always accepted
      else
         in_ready = |(writable & sel_hit);
   end

   always_ff @(posedge clk) begin
      if (reset)
         sel_err <= 1'b0;
      else if (in_valid && !in_bcast && sel_oor)
         sel_err <= 1'b1;
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_ch
      assign sel_hit[k] = (in_sel == SEL_W'(k));
      assign wr_en[k]   = in_valid && in_ready && (in_bcast || sel_hit[k]);

      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (wr_en[k]),
         .wr_data  (in_data),
         .rd_ready (out_ready[k]),
         .valid    (out_valid[k]),
         .data     (out_data[k*WIDTH +: WIDTH]),
         .writable (writable[k])
`ifdef DEMUX_COUNT_EN
         ,
         .cnt      (cnt_out[k*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_demux_router_n.sv
// tb_demux_router_n: randomized + directed bench for demux_router_n
// (WIDTH=8, N_OUT=5 so selectors 5..7 are out of range). Stimulus is driven
// at the falling edge; a monitor samples #1 later, compares the DUT against a
// queue-per-channel scoreboard and then advances the model for the next edge.
module tb_demux_router_n;
   localparam int W  = 8;
   localparam int N  = 5;
   localparam int SW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready, in_bcast, sel_err;
   logic [W-1:0]    in_data;
   logic [SW-1:0]   in_sel;
   logic [N-1:0]    out_valid, out_ready;
   logic [N*W-1:0]  out_data;
`ifdef DEMUX_COUNT_EN
   logic [N*16-1:0] cnt_out;
`endif

   always #5 clk = ~clk;

   demux_router_n #(.WIDTH(W), .N_OUT(N)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel_err(sel_err)
`ifdef DEMUX_COUNT_EN
      , .cnt_out(cnt_out)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   logic [W-1:0] q[N][$];   // words each channel should be presenting
   bit           m_err;
   bit           chk_zero;
   int           m_cnt[N];

   always begin
      @(negedge clk);
      #1;
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            q[k].delete();
            m_cnt[k] = 0;
         end
         m_err    = 0;
         chk_zero = 1;
      end else begin
         logic [N-1:0] ok, ev;
         logic         er;
         for (int k = 0; k < N; k++) begin
            ok[k] = (q[k].size() == 0) || out_ready[k];
            ev[k] = (q[k].size() != 0);
         end
         if (in_bcast)          er = &ok;
         else if (int'(in_sel) >= N) er = 1'b1;
         else                   er = ok[in_sel];
         chk("in_ready", 96'(in_ready), 96'(er));
         chk("out_valid", 96'(out_valid), 96'(ev));
         for (int k = 0; k < N; k++)
            if (ev[k]) chk($sformatf("out_data[%0d]", k), 96'(out_data[k*W +: W]), 96'(q[k][0]));
         if (chk_zero) chk("out_data_after_reset", 96'(out_data), 96'(0));
         chk_zero = 0;
         chk("sel_err", 96'(sel_err), 96'(m_err));
`ifdef DEMUX_COUNT_EN
         for (int k = 0; k < N; k++)
            chk($sformatf("cnt_out[%0d]", k), 96'(cnt_out[k*16 +: 16]), 96'(m_cnt[k] & 16'hFFFF));
`endif
         // advance the model across the coming edge
         for (int k = 0; k < N; k++)
            if (ev[k] && out_ready[k]) begin
               void'(q[k].pop_front());
               m_cnt[k]++;
            end
         if (in_valid && er) begin
            if (in_bcast)               for (int k = 0; k < N; k++) q[k].push_back(in_data);
            else if (int'(in_sel) < N)  q[in_sel].push_back(in_data);
            else                        m_err = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic b, input logic [W-1:0] d,
                        input logic [SW-1:0] s, input logic [N-1:0] r, input logic rst = 1'b0);
      reset = rst; in_valid = v; in_bcast = b; in_data = d; in_sel = s; out_ready = r;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; in_valid = 0; in_bcast = 0; in_data = 0; in_sel = 0; out_ready = 0;
      @(negedge clk);
      drive(1, 0, 8'h11, 3'd0, 5'h1F, 1);          // reset wins over handshakes
      // unicast hold: second word to ch2 blocked until its consumer is ready
      drive(1, 0, 8'hA5, 3'd2, 5'h00);
      drive(1, 0, 8'h5A, 3'd2, 5'h00);
      drive(1, 0, 8'h5A, 3'd2, 5'h00);
      drive(1, 0, 8'h5A, 3'd2, 5'b00100);          // pass-through refill
      drive(0, 0, 8'h00, 3'd0, 5'b00100);
      // streaming 0..7 on ch1
      for (int i = 0; i < 8; i++) drive(1, 0, W'(i), 3'd1, 5'b00010);
      drive(0, 0, 8'h00, 3'd0, 5'b00010);
      // broadcast blocked by full ch3
      drive(1, 0, 8'h77, 3'd3, 5'h00);
      drive(1, 1, 8'h3C, 3'd0, 5'h00);
      drive(1, 1, 8'h3C, 3'd0, 5'h00);
      drive(1, 1, 8'h3C, 3'd0, 5'b01000);
      drive(0, 0, 8'h00, 3'd0, 5'h00);
      drive(0, 0, 8'h00, 3'd0, 5'h1F);
      // out-of-range selectors
      drive(1, 0, 8'hEE, 3'd5, 5'h00);
      drive(0, 0, 8'h00, 3'd0, 5'h00);
      drive(1, 0, 8'hEF, 3'd7, 5'h00);
      drive(0, 0, 8'h00, 3'd0, 5'h00);
      // fill ch0/ch2 then reset with every consumer ready
      drive(1, 0, 8'h01, 3'd0, 5'h00);
      drive(1, 0, 8'h02, 3'd2, 5'h00);
      drive(1, 1, 8'h99, 3'd0, 5'h1F, 1);
      drive(0, 0, 8'h00, 3'd0, 5'h00);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [SW-1:0] s;
         s = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(5, 7)) : SW'($urandom_range(0, 4));
         drive(1'($urandom), ($urandom_range(0, 7) == 0), W'($urandom), s,
               N'($urandom), ($urandom_range(0, 299) == 0));
      end
`ifdef DEMUX_COUNT_EN
      drive(0, 0, 8'h00, 3'd0, 5'h00, 1);
      for (int i = 0; i < 65537; i++) drive(1, 0, W'(i), 3'd0, 5'b00001);
      drive(0, 0, 8'h00, 3'd0, 5'b00001);
      #2;
      chk("cnt_wrap_ch0", 96'(cnt_out[15:0]), 96'(16'd1));
      chk("cnt_others", 96'(cnt_out[N*16-1:16]), 96'(0));
`endif
      drive(0, 0, 8'h00, 3'd0, 5'h1F);
      drive(0, 0, 8'h00, 3'd0, 5'h1F);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
